// File: rtl/aes_job_sequencer.sv
// Job-level controller for the AES memory datapath: holds one active copy/encrypt job plus one
// pending job, launches the read and write engines together and reports completion.
module aes_job_sequencer #(
  parameter int unsigned CYCLE_CNT_W = 32,
  parameter int unsigned JOB_CNT_W   = 32,
  parameter int unsigned CL_ADDR_W   = 42
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // Job submission from CSR decode
  input  logic                   job_start_i,
  input  logic [CL_ADDR_W-1:0]   job_src_cl_addr_i,
  input  logic [CL_ADDR_W-1:0]   job_dst_cl_addr_i,
  input  logic [63:0]            job_length_i,
  output logic                   job_accept_o,
  output logic                   job_done_o,
  output logic                   busy_o,
  output logic                   overflow_o,
  input  logic                   overflow_clr_i,
  output logic [JOB_CNT_W-1:0]   jobs_completed_o,
  output logic [CYCLE_CNT_W-1:0] last_job_cycles_o,
  // Read engine
  output logic                   rd_run_o,
  output logic [CL_ADDR_W-1:0]   rd_first_cl_addr_o,
  output logic [63:0]            rd_data_length_o,
  input  logic                   rd_done_i,
  // Write engine
  output logic                   wr_run_o,
  output logic [CL_ADDR_W-1:0]   wr_first_cl_addr_o,
  output logic [63:0]            wr_data_length_o,
  input  logic                   wr_done_i
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StComplete} state_e;

  state_e                 state_q, state_d;
  logic [CL_ADDR_W-1:0]   act_src_q, act_src_d, act_dst_q, act_dst_d;
  logic [63:0]            act_len_q, act_len_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [CL_ADDR_W-1:0]   pend_src_q, pend_src_d, pend_dst_q, pend_dst_d;
  logic [63:0]            pend_len_q, pend_len_d;
  logic                   rd_fin_q, rd_fin_d, wr_fin_q, wr_fin_d;
  logic                   guard_q;
  logic                   overflow_q, overflow_d;
  logic [CYCLE_CNT_W-1:0] cyc_q, cyc_d;
  logic [CYCLE_CNT_W-1:0] last_cyc_q, last_cyc_d;
  logic [JOB_CNT_W-1:0]   jobs_q, jobs_d;
  logic                   take;
  logic                   run_pulse;

  // Next-state, job queueing and per-job bookkeeping
  always_comb begin
    state_d      = state_q;
    act_src_d    = act_src_q;
    act_dst_d    = act_dst_q;
    act_len_d    = act_len_q;
    pend_valid_d = pend_valid_q;
    pend_src_d   = pend_src_q;
    pend_dst_d   = pend_dst_q;
    pend_len_d   = pend_len_q;
    rd_fin_d     = rd_fin_q;
    wr_fin_d     = wr_fin_q;
    cyc_d        = cyc_q;
    last_cyc_d   = last_cyc_q;
    jobs_d       = jobs_q;
    run_pulse    = 1'b0;
    job_done_o   = 1'b0;

    // COMPLETE with a pending job pops and pushes in the same cycle
    job_accept_o = (state_q == StIdle) || !pend_valid_q || (state_q == StComplete);
    take         = job_start_i && job_accept_o;
    overflow_d   = (job_start_i && !job_accept_o) || (overflow_q && !overflow_clr_i);

    unique case (state_q)
      StIdle: begin
        if (job_start_i) begin
          act_src_d = job_src_cl_addr_i;
          act_dst_d = job_dst_cl_addr_i;
          act_len_d = job_length_i;
          state_d   = StLaunch;
        end
      end
      StLaunch: begin
        rd_fin_d  = 1'b0;
        wr_fin_d  = 1'b0;
        run_pulse = (act_len_q != 64'd0);
        state_d   = run_pulse ? StRun : StComplete;
      end
      StRun: begin
        // Engine done levels are stale until the run pulse has registered in the engines
        if (!guard_q) begin
          rd_fin_d = rd_fin_q || rd_done_i;
          wr_fin_d = wr_fin_q || wr_done_i;
          if ((rd_fin_q || rd_done_i) && (wr_fin_q || wr_done_i)) state_d = StComplete;
        end
      end
      StComplete: begin
        job_done_o = 1'b1;
        jobs_d     = jobs_q + JOB_CNT_W'(1);
        last_cyc_d = cyc_q;
        if (pend_valid_q) begin
          act_src_d    = pend_src_q;
          act_dst_d    = pend_dst_q;
          act_len_d    = pend_len_q;
          pend_valid_d = 1'b0;
          state_d      = StLaunch;
        end else if (take) begin
          // Empty slot: a job arriving now launches directly instead of parking in pending
          act_src_d = job_src_cl_addr_i;
          act_dst_d = job_dst_cl_addr_i;
          act_len_d = job_length_i;
          state_d   = StLaunch;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take && (state_q != StIdle) && !((state_q == StComplete) && !pend_valid_q)) begin
      pend_valid_d = 1'b1;
      pend_src_d   = job_src_cl_addr_i;
      pend_dst_d   = job_dst_cl_addr_i;
      pend_len_d   = job_length_i;
    end

    if (state_d == StLaunch) begin
      cyc_d = '0;
    end else if (((state_q == StLaunch) || (state_q == StRun)) && (cyc_q != '1)) begin
      cyc_d = cyc_q + CYCLE_CNT_W'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      act_src_q    <= '0;
      act_dst_q    <= '0;
      act_len_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_src_q   <= '0;
      pend_dst_q   <= '0;
      pend_len_q   <= '0;
      rd_fin_q     <= 1'b0;
      wr_fin_q     <= 1'b0;
      guard_q      <= 1'b0;
      overflow_q   <= 1'b0;
      cyc_q        <= '0;
      last_cyc_q   <= '0;
      jobs_q       <= '0;
    end else begin
      state_q      <= state_d;
      act_src_q    <= act_src_d;
      act_dst_q    <= act_dst_d;
      act_len_q    <= act_len_d;
      pend_valid_q <= pend_valid_d;
      pend_src_q   <= pend_src_d;
      pend_dst_q   <= pend_dst_d;
      pend_len_q   <= pend_len_d;
      rd_fin_q     <= rd_fin_d;
      wr_fin_q     <= wr_fin_d;
      guard_q      <= (state_q == StLaunch);
      overflow_q   <= overflow_d;
      cyc_q        <= cyc_d;
      last_cyc_q   <= last_cyc_d;
      jobs_q       <= jobs_d;
    end
  end

  // Engine-facing and status outputs
  always_comb begin
    rd_run_o           = run_pulse;
    wr_run_o           = run_pulse;
    rd_first_cl_addr_o = act_src_q;
    wr_first_cl_addr_o = act_dst_q;
    rd_data_length_o   = act_len_q;
    wr_data_length_o   = act_len_q;
    busy_o             = (state_q != StIdle) || pend_valid_q;
    overflow_o         = overflow_q;
    jobs_completed_o   = jobs_q;
    last_job_cycles_o  = last_cyc_q;
  end

endmodule

// File: tb/tb_aes_job_sequencer.sv
// Scoreboard bench for aes_job_sequencer: accepted jobs are queued with their expected engine
// parameters and checked when the DUT launches and completes them.
module tb_aes_job_sequencer;

  typedef struct packed {
    logic [41:0] src;
    logic [41:0] dst;
    logic [63:0] len;
  } job_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        job_start_i;
  logic [41:0] job_src_cl_addr_i, job_dst_cl_addr_i;
  logic [63:0] job_length_i;
  logic        job_accept_o, job_done_o, busy_o, overflow_o, overflow_clr_i;
  logic [31:0] jobs_completed_o, last_job_cycles_o;
  logic        rd_run_o, wr_run_o, rd_done_i, wr_done_i;
  logic [41:0] rd_first_cl_addr_o, wr_first_cl_addr_o;
  logic [63:0] rd_data_length_o, wr_data_length_o;

  int   checks   = 0;
  int   failures = 0;
  int   exp_jobs = 0;
  job_t sb[$];

  aes_job_sequencer dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .job_start_i       (job_start_i),
    .job_src_cl_addr_i (job_src_cl_addr_i),
    .job_dst_cl_addr_i (job_dst_cl_addr_i),
    .job_length_i      (job_length_i),
    .job_accept_o      (job_accept_o),
    .job_done_o        (job_done_o),
    .busy_o            (busy_o),
    .overflow_o        (overflow_o),
    .overflow_clr_i    (overflow_clr_i),
    .jobs_completed_o  (jobs_completed_o),
    .last_job_cycles_o (last_job_cycles_o),
    .rd_run_o          (rd_run_o),
    .rd_first_cl_addr_o(rd_first_cl_addr_o),
    .rd_data_length_o  (rd_data_length_o),
    .rd_done_i         (rd_done_i),
    .wr_run_o          (wr_run_o),
    .wr_first_cl_addr_o(wr_first_cl_addr_o),
    .wr_data_length_o  (wr_data_length_o),
    .wr_done_i         (wr_done_i)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard: engine parameters at launch and at completion must match the queued job
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rd_run_o) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_launch: run pulse with empty scoreboard");
        end else if (rd_first_cl_addr_o !== sb[0].src || wr_first_cl_addr_o !== sb[0].dst ||
                     rd_data_length_o !== sb[0].len || wr_data_length_o !== sb[0].len) begin
          failures++;
          $display("FAIL sb_launch: got src=%h dst=%h len=%0d/%0d expected src=%h dst=%h len=%0d",
                   rd_first_cl_addr_o, wr_first_cl_addr_o, rd_data_length_o, wr_data_length_o,
                   sb[0].src, sb[0].dst, sb[0].len);
        end
      end
      if (job_done_o) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_done: job_done with empty scoreboard");
        end else begin
          job_t j;
          j = sb.pop_front();
          if (rd_first_cl_addr_o !== j.src || wr_first_cl_addr_o !== j.dst ||
              rd_data_length_o !== j.len) begin
            failures++;
            $display("FAIL sb_done: got src=%h dst=%h len=%0d expected src=%h dst=%h len=%0d",
                     rd_first_cl_addr_o, wr_first_cl_addr_o, rd_data_length_o,
                     j.src, j.dst, j.len);
          end
        end
      end
    end
  end

  task automatic drive_job(input logic start, input logic [41:0] src, input logic [41:0] dst,
                           input logic [63:0] len, input logic will_accept);
    job_t j;
    job_start_i       = start;
    job_src_cl_addr_i = src;
    job_dst_cl_addr_i = dst;
    job_length_i      = len;
    if (start && will_accept) begin
      j.src = src;
      j.dst = dst;
      j.len = len;
      sb.push_back(j);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_job(1'b0, '0, '0, '0, 1'b0);
    overflow_clr_i = 1'b0;
    rd_done_i = 1'b1;
    wr_done_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    checks++;
    if ({rd_run_o, wr_run_o, job_done_o, busy_o, overflow_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 00000",
               {rd_run_o, wr_run_o, job_done_o, busy_o, overflow_o});
    end
    checks++;
    if (jobs_completed_o !== 32'd0 || last_job_cycles_o !== 32'd0) begin
      failures++;
      $display("FAIL reset_counters: got jobs=%0d cycles=%0d expected 0/0",
               jobs_completed_o, last_job_cycles_o);
    end
    checks++;
    if (rd_first_cl_addr_o !== 42'd0 || wr_first_cl_addr_o !== 42'd0 ||
        rd_data_length_o !== 64'd0 || wr_data_length_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_engine_params: got %h %h %0d %0d expected all 0",
               rd_first_cl_addr_o, wr_first_cl_addr_o, rd_data_length_o, wr_data_length_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_single();
    for (int c = 0; c < 17; c++) begin
      @(posedge clk_i); #1;
      drive_job(c == 0, 42'h1000, 42'h2000, 64'd4, 1'b1);
      rd_done_i = (c < 2) || (c >= 10);
      wr_done_i = (c < 2) || (c >= 14);
      if (c == 15) exp_jobs++;
      #1;
      checks++;
      if (rd_run_o !== (c == 1) || wr_run_o !== (c == 1)) begin
        failures++;
        $display("FAIL single_run c=%0d: got rd=%b wr=%b expected %b", c, rd_run_o, wr_run_o,
                 c == 1);
      end
      checks++;
      if (job_done_o !== (c == 15)) begin
        failures++;
        $display("FAIL single_done c=%0d: got %b expected %b", c, job_done_o, c == 15);
      end
    end
    checks++;
    if (jobs_completed_o !== 32'(exp_jobs) || last_job_cycles_o !== 32'd14) begin
      failures++;
      $display("FAIL single_counters: got jobs=%0d cycles=%0d expected %0d/14",
               jobs_completed_o, last_job_cycles_o, exp_jobs);
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 14; c++) begin
      @(posedge clk_i); #1;
      if (c == 3) drive_job(1'b1, 42'h5000, 42'h6000, 64'd3, 1'b1);
      else        drive_job(c == 0, 42'h3000, 42'h4000, 64'd2, 1'b1);
      rd_done_i = !(((c >= 2) && (c < 5)) || ((c >= 8) && (c < 11)));
      wr_done_i = rd_done_i;
      if (c == 6 || c == 12) exp_jobs++;
      #1;
      if (c == 3) begin
        checks++;
        if (job_accept_o !== 1'b1) begin
          failures++;
          $display("FAIL b2b_accept: got %b expected 1", job_accept_o);
        end
      end
      if (c == 6) begin
        checks++;
        if (rd_first_cl_addr_o !== 42'h3000) begin
          failures++;
          $display("FAIL b2b_addr_held: got %h expected 3000", rd_first_cl_addr_o);
        end
      end
      checks++;
      if (rd_run_o !== (c == 1 || c == 7)) begin
        failures++;
        $display("FAIL b2b_run c=%0d: got %b expected %b", c, rd_run_o, c == 1 || c == 7);
      end
      checks++;
      if (job_done_o !== (c == 6 || c == 12)) begin
        failures++;
        $display("FAIL b2b_done c=%0d: got %b expected %b", c, job_done_o, c == 6 || c == 12);
      end
      checks++;
      if (busy_o !== (c >= 1 && c <= 12)) begin
        failures++;
        $display("FAIL b2b_busy c=%0d: got %b expected %b", c, busy_o, c >= 1 && c <= 12);
      end
    end
  endtask

  task automatic test_overflow();
    logic exp_acc;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk_i); #1;
      exp_acc = (c < 2);
      drive_job(c <= 3, 42'h7000 + 42'(c) * 42'h2000, 42'h8000 + 42'(c) * 42'h2000,
                (c == 0) ? 64'd3 : 64'd1, exp_acc);
      overflow_clr_i = (c == 3) || (c == 4);
      rd_done_i = !((c >= 2) && (c < 8));
      wr_done_i = rd_done_i;
      if (c == 9 || c == 13) exp_jobs++;
      #1;
      if (c <= 3) begin
        checks++;
        if (job_accept_o !== exp_acc) begin
          failures++;
          $display("FAIL ovf_accept c=%0d: got %b expected %b", c, job_accept_o, exp_acc);
        end
      end
      checks++;
      if (overflow_o !== (c == 3 || c == 4)) begin
        failures++;
        $display("FAIL ovf_flag c=%0d: got %b expected %b", c, overflow_o, c == 3 || c == 4);
      end
      checks++;
      if (job_done_o !== (c == 9 || c == 13)) begin
        failures++;
        $display("FAIL ovf_done c=%0d: got %b expected %b", c, job_done_o, c == 9 || c == 13);
      end
    end
    overflow_clr_i = 1'b0;
  endtask

  task automatic test_zero_len();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i); #1;
      drive_job(c == 0, 42'hD000, 42'hE000, 64'd0, 1'b1);
      rd_done_i = 1'b1;
      wr_done_i = 1'b1;
      if (c == 2) exp_jobs++;
      #1;
      checks++;
      if (rd_run_o !== 1'b0 || wr_run_o !== 1'b0) begin
        failures++;
        $display("FAIL zero_run c=%0d: got rd=%b wr=%b expected 0", c, rd_run_o, wr_run_o);
      end
      checks++;
      if (job_done_o !== (c == 2)) begin
        failures++;
        $display("FAIL zero_done c=%0d: got %b expected %b", c, job_done_o, c == 2);
      end
    end
    checks++;
    if (last_job_cycles_o !== 32'd1 || jobs_completed_o !== 32'(exp_jobs)) begin
      failures++;
      $display("FAIL zero_counters: got cycles=%0d jobs=%0d expected 1/%0d",
               last_job_cycles_o, jobs_completed_o, exp_jobs);
    end
  endtask

  task automatic test_stale_done();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk_i); #1;
      drive_job(c == 0, 42'h10000, 42'h11000, 64'd1, 1'b1);
      rd_done_i = 1'b1;
      wr_done_i = 1'b1;
      if (c == 4) exp_jobs++;
      #1;
      checks++;
      if (job_done_o !== (c == 4)) begin
        failures++;
        $display("FAIL stale_done c=%0d: got %b expected %b", c, job_done_o, c == 4);
      end
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      drive_job(c == 0, 42'h12000, 42'h13000, 64'd2, 1'b1);
      rd_done_i = (c < 2) || (c == 6);
      wr_done_i = (c < 2) || (c >= 9);
      if (c == 10) exp_jobs++;
      #1;
      checks++;
      if (job_done_o !== (c == 10)) begin
        failures++;
        $display("FAIL unequal_done c=%0d: got %b expected %b", c, job_done_o, c == 10);
      end
    end
    checks++;
    if (last_job_cycles_o !== 32'd9 || jobs_completed_o !== 32'(exp_jobs)) begin
      failures++;
      $display("FAIL unequal_counters: got cycles=%0d jobs=%0d expected 9/%0d",
               last_job_cycles_o, jobs_completed_o, exp_jobs);
    end
  endtask

  task automatic test_reset_mid_run();
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      if (c == 1)      drive_job(1'b1, 42'h22000, 42'h23000, 64'd2, 1'b1);
      else if (c >= 6) drive_job(c == 6, 42'h24000, 42'h25000, 64'd1, 1'b1);
      else             drive_job(c == 0, 42'h20000, 42'h21000, 64'd5, 1'b1);
      rd_done_i = (c < 2) || (c >= 6);
      wr_done_i = rd_done_i;
      if (c == 4) begin
        rst_ni = 1'b0;
        sb.delete();
        exp_jobs = 0;
      end
      if (c == 5) rst_ni = 1'b1;
      if (c == 10) exp_jobs++;
      #1;
      if (c == 4) begin
        checks++;
        if ({rd_run_o, wr_run_o, job_done_o, busy_o, overflow_o} !== 5'b0 ||
            jobs_completed_o !== 32'd0 || last_job_cycles_o !== 32'd0 ||
            rd_first_cl_addr_o !== 42'd0 || wr_data_length_o !== 64'd0) begin
          failures++;
          $display("FAIL midreset_outputs: got flags=%b jobs=%0d cycles=%0d src=%h len=%0d expected all 0",
                   {rd_run_o, wr_run_o, job_done_o, busy_o, overflow_o}, jobs_completed_o,
                   last_job_cycles_o, rd_first_cl_addr_o, wr_data_length_o);
        end
      end
      if (c == 5) begin
        checks++;
        if (busy_o !== 1'b0) begin
          failures++;
          $display("FAIL midreset_pending_cleared: got busy=%b expected 0", busy_o);
        end
      end
      if (c == 6) begin
        checks++;
        if (job_accept_o !== 1'b1) begin
          failures++;
          $display("FAIL midreset_accept: got %b expected 1", job_accept_o);
        end
      end
      if (c >= 6) begin
        checks++;
        if (rd_run_o !== (c == 7) || job_done_o !== (c == 10)) begin
          failures++;
          $display("FAIL midreset_newjob c=%0d: got run=%b done=%b expected %b/%b", c,
                   rd_run_o, job_done_o, c == 7, c == 10);
        end
      end
    end
    checks++;
    if (jobs_completed_o !== 32'(exp_jobs)) begin
      failures++;
      $display("FAIL midreset_jobs: got %0d expected %0d", jobs_completed_o, exp_jobs);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_zero_len();
    test_stale_done();
    test_reset_mid_run();
    repeat (2) @(posedge clk_i);
    #2;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d jobs outstanding expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
